// File: rtl/adder_share_arb_if.sv
// Request/result bundle between the shared adder and its requesters.
// Ports: req/op_a/op_b/stall driven by the requester side (master);
//        ack/sum/cout/res_valid/res_id driven by the arbiter (slave).
interface adder_share_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic                  stall;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      sum;
  logic                  cout;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;

  modport master (
    output req, op_a, op_b, stall,
    input  ack, sum, cout, res_valid, res_id
  );

  modport slave (
    input  req, op_a, op_b, stall,
    output ack, sum, cout, res_valid, res_id
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters.
// Latency: 1 cycle from an uncontested request to its ack/registered sum.
// Backpressure: stall freezes grants and holds outputs; requests stay pending.
// Ports: clk, rst (sync, active-high); bus (slave modport of adder_share_arb_if).
// Optional: define ADDER_SHARE_ARB_PRIO0_EN to give client 0 fixed top priority.
module adder_share_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  adder_share_arb_if.slave bus
);

  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  eligible;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [IDW-1:0]   res_id_q;
  logic [IDW-1:0]   lw_q;
  logic [IDW-1:0]   win;
  logic             grant;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum_d;

  always_comb begin
    // A client acked this cycle is still holding req; exclude it so one
    // request never produces two grants.
    eligible = bus.req & ~ack_q;
    grant    = 1'b0;
    win      = '0;
    ack_d    = '0;
    a_sel    = '0;
    b_sel    = '0;
    // Scan distance k = 1..NREQ from the last winner; the inner loop keeps
    // every index constant so the match is a flat compare per (k, i) pair.
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant && eligible[i] &&
            ((int'(lw_q) + k == i) || (int'(lw_q) + k == i + NREQ))) begin
          grant    = 1'b1;
          win      = IDW'(i);
          ack_d    = '0;
          ack_d[i] = 1'b1;
          a_sel    = bus.op_a[i*WIDTH +: WIDTH];
          b_sel    = bus.op_b[i*WIDTH +: WIDTH];
        end
      end
    end
`ifdef ADDER_SHARE_ARB_PRIO0_EN
    // Client 0 overrides the rotation whenever it is eligible.
    if (eligible[0]) begin
      grant    = 1'b1;
      win      = '0;
      ack_d    = '0;
      ack_d[0] = 1'b1;
      a_sel    = bus.op_a[WIDTH-1:0];
      b_sel    = bus.op_b[WIDTH-1:0];
    end
`else
`endif
    sum_d = {1'b0, a_sel} + {1'b0, b_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      res_id_q <= '0;
      lw_q     <= IDW'(NREQ - 1);
    end else if (!bus.stall && grant) begin
      ack_q    <= ack_d;
      sum_q    <= sum_d[WIDTH-1:0];
      cout_q   <= sum_d[WIDTH];
      res_id_q <= win;
      lw_q     <= win;
    end else begin
      ack_q    <= '0;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.res_valid = |ack_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed table-driven bench for adder_share_arb (NREQ=3, WIDTH=32).
module tb_adder_share_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  adder_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  adder_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rq;
    logic [31:0] a0, a1, a2, b0, b1, b2;
    logic        st;
    logic [2:0]  e_ack;
    logic [31:0] e_sum;
    logic        e_cout;
    logic [1:0]  e_id;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] rq, input logic [31:0] a0, a1, a2,
                       input logic [31:0] b0, b1, b2, input logic st);
    bus.req   = rq;
    bus.op_a  = {a2, a1, a0};
    bus.op_b  = {b2, b1, b0};
    bus.stall = st;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_ack, input logic [31:0] e_sum,
                         input logic e_cout, input logic [1:0] e_id);
    chk({tag, " ack"},       32'(bus.ack),       32'(e_ack));
    chk({tag, " sum"},       bus.sum,            e_sum);
    chk({tag, " cout"},      32'(bus.cout),      32'(e_cout));
    chk({tag, " res_id"},    32'(bus.res_id),    32'(e_id));
    chk({tag, " res_valid"}, 32'(bus.res_valid), 32'(|e_ack));
  endtask

  initial begin
    // Rotation with a_i=i, b_i=10, then a drain cycle.
`ifdef ADDER_SHARE_ARB_PRIO0_EN
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b001, 32'd10, 1'b0, 2'd0});
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b010, 32'd11, 1'b0, 2'd1});
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b001, 32'd10, 1'b0, 2'd0});
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b010, 32'd11, 1'b0, 2'd1});
    vt.push_back('{3'b000, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b000, 32'd11, 1'b0, 2'd1});
`else
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b001, 32'd10, 1'b0, 2'd0});
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b010, 32'd11, 1'b0, 2'd1});
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b100, 32'd12, 1'b0, 2'd2});
    vt.push_back('{3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b001, 32'd10, 1'b0, 2'd0});
    vt.push_back('{3'b000, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0, 3'b000, 32'd10, 1'b0, 2'd0});
`endif
    // Single client 1: 5+7, then req dropped and sum holds.
    vt.push_back('{3'b010, 32'd0, 32'd5, 32'd2, 32'd10, 32'd7, 32'd10, 1'b0, 3'b010, 32'd12, 1'b0, 2'd1});
    vt.push_back('{3'b000, 32'd0, 32'd5, 32'd2, 32'd10, 32'd7, 32'd10, 1'b0, 3'b000, 32'd12, 1'b0, 2'd1});
    // Overflow: FFFFFFFF+1, then another client, then 80000000+80000000.
    vt.push_back('{3'b001, 32'hFFFF_FFFF, 32'd5, 32'd2, 32'd1, 32'd7, 32'd10, 1'b0, 3'b001, 32'd0, 1'b1, 2'd0});
    vt.push_back('{3'b010, 32'hFFFF_FFFF, 32'd5, 32'd2, 32'd1, 32'd7, 32'd10, 1'b0, 3'b010, 32'd12, 1'b0, 2'd1});
    vt.push_back('{3'b001, 32'h8000_0000, 32'd5, 32'd2, 32'h8000_0000, 32'd7, 32'd10, 1'b0, 3'b001, 32'd0, 1'b1, 2'd0});
    // Client 0 slow to drop req: no second grant for the same request.
    vt.push_back('{3'b001, 32'h8000_0000, 32'd5, 32'd2, 32'h8000_0000, 32'd7, 32'd10, 1'b0, 3'b000, 32'd0, 1'b1, 2'd0});
    // Stall for three cycles with req=101: nothing moves.
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b1, 3'b000, 32'd0, 1'b1, 2'd0});
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b1, 3'b000, 32'd0, 1'b1, 2'd0});
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b1, 3'b000, 32'd0, 1'b1, 2'd0});
    // Stall released: last winner was 0, so client 2 then client 0.
`ifdef ADDER_SHARE_ARB_PRIO0_EN
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b0, 3'b001, 32'd3, 1'b0, 2'd0});
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b0, 3'b100, 32'd7, 1'b0, 2'd2});
    vt.push_back('{3'b000, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b0, 3'b000, 32'd7, 1'b0, 2'd2});
`else
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b0, 3'b100, 32'd7, 1'b0, 2'd2});
    vt.push_back('{3'b101, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b0, 3'b001, 32'd3, 1'b0, 2'd0});
    vt.push_back('{3'b000, 32'd1, 32'd5, 32'd3, 32'd2, 32'd7, 32'd4, 1'b0, 3'b000, 32'd3, 1'b0, 2'd0});
`endif

    // Reset held for two edges with all clients requesting.
    rst = 1'b1;
    drive(3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b0);
    for (int r = 0; r < 2; r++) begin
      step();
      chk_all($sformatf("reset%0d", r), 3'b000, 32'd0, 1'b0, 2'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rq, vt[i].a0, vt[i].a1, vt[i].a2, vt[i].b0, vt[i].b1, vt[i].b2, vt[i].st);
      step();
      chk_all($sformatf("row%0d", i), vt[i].e_ack, vt[i].e_sum, vt[i].e_cout, vt[i].e_id);
    end

    // Reset mid-run with stall and req high: reset wins, and the pointer
    // returns to NREQ-1 so client 0 is granted first afterwards.
    rst = 1'b1;
    drive(3'b111, 32'd0, 32'd1, 32'd2, 32'd10, 32'd10, 32'd10, 1'b1);
    step();
    chk_all("rst_mid", 3'b000, 32'd0, 1'b0, 2'd0);
    rst = 1'b0;
    bus.stall = 1'b0;
    step();
    chk_all("post_rst0", 3'b001, 32'd10, 1'b0, 2'd0);
    step();
    chk_all("post_rst1", 3'b010, 32'd11, 1'b0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
